// File: rtl/cs_window_filter.sv
// cs_window_filter: sliding-window approximate-average filter, Y = (sum + WIN*Xappr) >> SHIFT
module cs_window_filter #(
    parameter int DATA_W = 8,
    parameter int WIN    = 9,
    parameter int SHIFT  = 3,
    parameter int OUT_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic              mode,
    input  logic [DATA_W-1:0] X,
    output logic [OUT_W-1:0]  Y,
    output logic              out_valid
);
    localparam int SUM_W = DATA_W + $clog2(WIN);
    localparam int CNT_W = $clog2(WIN + 1);

    logic [DATA_W-1:0] win_q [WIN];
    logic [SUM_W-1:0]  sum_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              pend;
    logic              mode_q;
    logic [DATA_W-1:0] xappr;
    logic [SUM_W-1:0]  prod;
    logic [SUM_W:0]    y_full;
    logic              full_next;

    assign full_next = cnt_q >= CNT_W'(WIN - 1);

    // Exact s*WIN vs sum compares replace a divider for the average.
    always_comb begin
        xappr = mode_q ? '1 : '0;
        prod  = '0;
        for (int i = 0; i < WIN; i++) begin
            prod = SUM_W'(win_q[i]) * SUM_W'(WIN);
            if (!mode_q && prod <= sum_q && win_q[i] > xappr) xappr = win_q[i];
            if (mode_q && prod >= sum_q && win_q[i] < xappr) xappr = win_q[i];
        end
        y_full = {1'b0, sum_q} + (SUM_W + 1)'(SUM_W'(xappr) * SUM_W'(WIN));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < WIN; i++) win_q[i] <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            pend      <= 1'b0;
            mode_q    <= 1'b0;
            Y         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= pend;
            if (pend) Y <= OUT_W'(y_full >> SHIFT);
            pend <= 1'b0;
            if (clear) begin
                for (int i = 0; i < WIN; i++) win_q[i] <= '0;
                sum_q <= '0;
                cnt_q <= '0;
            end else if (in_valid) begin
                win_q[0] <= X;
                for (int i = 1; i < WIN; i++) win_q[i] <= win_q[i-1];
                sum_q  <= sum_q - SUM_W'(win_q[WIN-1]) + SUM_W'(X);
                cnt_q  <= (cnt_q == CNT_W'(WIN)) ? cnt_q : cnt_q + 1'b1;
                pend   <= full_next;
                mode_q <= mode;
            end
        end
    end
endmodule

// File: tb/tb_cs_window_filter.sv
// tb_cs_window_filter: directed checks of fill latency, both modes, saturation, gaps, clear and reset.
module tb_cs_window_filter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] X = '0;
    logic [9:0] Y;
    logic       out_valid;
    int         checks = 0;
    int         errors = 0;

    cs_window_filter dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .mode(mode), .X(X), .Y(Y), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic v, input logic [7:0] x, input logic m, input logic c);
        in_valid = v;
        X        = x;
        mode     = m;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("rst_y", 16'(Y), 16'h000);
        chk("rst_ov", 16'(out_valid), 16'h0);
        reset = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            cyc(1, 8'(i), 0, 0);
            chk("fill_ov", 16'(out_valid), 16'h0);
        end
        cyc(1, 8'd10, 0, 0);
        chk("first_ov", 16'(out_valid), 16'h1);
        chk("first_y", 16'(Y), 16'h00B);
        cyc(0, 0, 0, 0);
        chk("next_ov", 16'(out_valid), 16'h1);
        chk("next_y", 16'(Y), 16'h00D);
        cyc(0, 0, 0, 0);
        chk("idle_ov", 16'(out_valid), 16'h0);
        chk("hold_y", 16'(Y), 16'h00D);
        // mode 0 on {0 x8, 10}
        for (int i = 0; i < 8; i++) cyc(1, 8'd0, 0, 0);
        cyc(1, 8'd10, 0, 0);
        cyc(0, 0, 0, 0);
        chk("m0_ov", 16'(out_valid), 16'h1);
        chk("m0_y", 16'(Y), 16'h001);
        // clear, then same window refilled in mode 1
        cyc(0, 0, 0, 1);
        chk("clr_ov", 16'(out_valid), 16'h0);
        chk("clr_y", 16'(Y), 16'h001);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 8'd0, 1, 0);
            chk("refill_ov", 16'(out_valid), 16'h0);
            chk("refill_y", 16'(Y), 16'h001);
        end
        cyc(1, 8'd10, 1, 0);
        chk("m1_pend_ov", 16'(out_valid), 16'h0);
        cyc(0, 0, 0, 0);
        chk("m1_ov", 16'(out_valid), 16'h1);
        chk("m1_y", 16'(Y), 16'h00C);
        // saturated window, then clear right behind the last accept
        for (int i = 0; i < 9; i++) cyc(1, 8'hFF, 0, 0);
        cyc(0, 0, 0, 1);
        chk("max_ov", 16'(out_valid), 16'h1);
        chk("max_y", 16'(Y), 16'h23D);
        cyc(0, 0, 0, 0);
        chk("post_clr_ov", 16'(out_valid), 16'h0);
        // gapped fill
        for (int i = 1; i <= 9; i++) begin
            cyc(1, 8'(i), 0, 0);
            chk("gap_acc_ov", 16'(out_valid), 16'h0);
            if (i < 9) begin
                cyc(0, 8'hEE, 1, 0);
                chk("gap_idle_ov", 16'(out_valid), 16'h0);
            end
        end
        cyc(0, 0, 0, 0);
        chk("gap_ov", 16'(out_valid), 16'h1);
        chk("gap_y", 16'(Y), 16'h00B);
        cyc(0, 0, 0, 0);
        chk("gap_end_ov", 16'(out_valid), 16'h0);
        // reset with a result in flight
        cyc(1, 8'd20, 0, 0);
        reset = 1'b0;
        cyc(0, 0, 0, 0);
        chk("mid_rst_ov", 16'(out_valid), 16'h0);
        chk("mid_rst_y", 16'(Y), 16'h000);
        reset = 1'b1;
        cyc(1, 8'd5, 0, 0);
        chk("after_rst_ov0", 16'(out_valid), 16'h0);
        cyc(0, 0, 0, 0);
        chk("after_rst_ov1", 16'(out_valid), 16'h0);
        chk("after_rst_y", 16'(Y), 16'h000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cs_window_filter.md
# cs_window_filter

Parametrised successor to the fixed 9-sample, 8-bit CS approximate-average filter. Accepts a serial sample stream under a valid qualifier and keeps a sliding window of the last WIN samples. For each accepted sample it outputs Y = (sum + WIN·Xappr) >> SHIFT, where Xappr is the window sample closest to the window average from below (mode 0) or from above (mode 1). It sits in the datapath front end and feeds downstream blocks through a one-cycle `out_valid` pulse.

## Interface

- DATA_W, 8, sample width (unsigned)
- WIN, 9, window depth in samples (≥ 2)
- SHIFT, 3, right shift applied to the final sum
- OUT_W, 10, output width; Y is the OUT_W LSBs of the shifted result (defaults give exact results)
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-low reset
- clear  input  1  synchronous window flush, active-high
- in_valid  input  1  X is accepted on this edge
- mode  input  1  approximation select, sampled with X
- X  input  DATA_W  sample
- Y  output  OUT_W  filter result, registered
- out_valid  output  1  Y is valid for this cycle, registered

## Operation

- Window: shift register of WIN samples plus a running `sum` of width DATA_W+clog2(WIN). On accept, the oldest sample leaves, X enters, and sum = sum − oldest + X.
- Fill counter `cnt` saturates at WIN. It increments on each accept until saturated.
- Xappr is computed on the post-update window, using exact integer compares and no divider:
  - mode 0: Xappr is the largest sample s with s·WIN ≤ sum, i.e. s ≤ floor(avg). The window minimum always qualifies.
  - mode 1: Xappr is the smallest sample s with s·WIN ≥ sum, i.e. s ≥ exact avg. The window maximum always qualifies.
  - Duplicate samples are allowed; the result depends only on the value.
- Result: Y = (sum + WIN·Xappr) >> SHIFT, computed at full precision (DATA_W+clog2(WIN)+1 bits), then truncated to OUT_W.
- `mode` is registered with the accepted sample and applies only to the result of that accept. Changing `mode` between accepts has no effect on the window.
- Priority at each edge is reset > clear > in_valid.
  - reset=0: window, sum, cnt, Y and out_valid all go to 0.
  - clear=1: window, sum and cnt go to 0, and out_valid goes to 0 on the next edge. Y holds its last value. in_valid on the same edge is ignored.
- While in_valid=0 the window and cnt hold, and out_valid is 0 on the next edge.

## Timing

- Reset values: Y = 0, out_valid = 0, window = 0, sum = 0, cnt = 0.
- Latency is 2 edges from sample to result:
  - edge k accepts X and updates the window/sum;
  - edge k+1 registers Y and sets out_valid = 1 for exactly one cycle.
- out_valid fires only for accepts that bring cnt to WIN or happen with cnt already at WIN. The first WIN−1 accepts after reset or clear produce no out_valid.
- A result needs a continuous valid window. If cnt < WIN, Y is not updated.
- Back-to-back accepts (in_valid held high) give one result per cycle at full throughput.
- Reset asserted mid-stream: the in-flight result is discarded, and out_valid is 0 on the edge after reset.
- clear on the edge after a full-window accept: the in-flight result still emits on that edge, because clear affects only subsequent state.
- Y holds between out_valid pulses.

## Test plan

- Defaults, reset low for 2 cycles, then samples 1..9 back-to-back in mode 0:
  - out_valid stays 0 for the first 8 accepts;
  - the 9th gives Y = 0x00B (sum 45, Xappr 5) with out_valid high for one cycle.
- Continue with sample 10: Y = 0x00D (window 2..10, sum 54, Xappr 6).
- Mode comparison on window {0,0,0,0,0,0,0,0,10} (sum 10):
  - mode 0 gives Xappr 0, Y = 0x001;
  - the same window in mode 1 gives Xappr 10, Y = 0x00C.
- Nine samples of 0xFF: Y = 0x23D, the maximum, with no truncation at OUT_W=10.
- Gaps and clear:
  - in_valid toggled 1,0,1,0 across the fill: out_valid only after the 9th accepted sample, and window contents are unaffected by gap cycles;
  - clear after a full window: the next 8 accepts give no out_valid, and Y holds its prior value.
- Reset mid-stream with a result in flight: out_valid = 0 and Y = 0 after the reset edge; a refill is required before the next result.
